// File: rtl/bram_pkg.sv
// Shared types, limits and helpers for the dual-port clearable block RAM.
// parity() is used by the RTL (BRAM_PARITY_EN builds) and by the testbench.
package bram_pkg;

   typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} bram_state_t;

   localparam int MAX_RD_LATENCY = 3;

   // Even-parity bit over up to 64 data bits; zero-extension leaves the XOR unchanged.
   function automatic logic parity(input logic [63:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-return pipeline placed after the registered array read: carries valid,
// data (and parity error when BRAM_PARITY_EN is defined) for RD_LATENCY stages.
module bram_rd_pipe
   import bram_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  vld_in,
   input  logic [DATA_WIDTH-1:0] data_in,
`ifdef BRAM_PARITY_EN
   input  logic                  perr_in,
   output logic                  perr,
`endif
   output logic [DATA_WIDTH-1:0] q,
   output logic                  valid
);

   logic [RD_LATENCY-1:0]                 vld_p;
   logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] data_p;

   // Data stages load only behind a valid so q holds between reads; the last
   // stage is the visible q, which must come out of reset as zero.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         vld_p  <= '0;
         data_p <= '0;
      end else begin
         vld_p[0] <= vld_in;
         if (vld_in) data_p[0] <= data_in;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_p[i] <= vld_p[i-1];
            if (vld_p[i-1]) data_p[i] <= data_p[i-1];
         end
      end
   end

   assign q     = data_p[RD_LATENCY-1];
   assign valid = vld_p[RD_LATENCY-1];

`ifdef BRAM_PARITY_EN
   logic [RD_LATENCY-1:0] perr_p;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         perr_p <= '0;
      end else begin
         perr_p[0] <= vld_in & perr_in;
         for (int i = 1; i < RD_LATENCY; i++) perr_p[i] <= perr_p[i-1];
      end
   end

   assign perr = perr_p[RD_LATENCY-1];
`endif

endmodule

// File: rtl/bram_dp_clr.sv
// Dual-port block RAM (A read/write, B read-only) with a hardware zero-sweep
// after reset and on clear; optional stored parity under BRAM_PARITY_EN.
module bram_dp_clr
   import bram_pkg::*;
#(
   parameter int MEMORY_DEPTH = 4096,
   parameter int DATA_WIDTH   = 16,
   parameter int RD_LATENCY   = 1,
   parameter int B_BYPASS     = 0
) (
   input  logic                            clk,
   input  logic                            rstN,
   input  logic                            clear,
   output logic                            busy,
   input  logic                            a_wr,
   input  logic                            a_rd,
   input  logic [$clog2(MEMORY_DEPTH)-1:0] a_address,
   input  logic [DATA_WIDTH-1:0]           a_data,
   output logic [DATA_WIDTH-1:0]           a_q,
   output logic                            a_valid,
   input  logic                            b_rd,
   input  logic [$clog2(MEMORY_DEPTH)-1:0] b_address,
   output logic [DATA_WIDTH-1:0]           b_q,
   output logic                            b_valid
`ifdef BRAM_PARITY_EN
   ,
   output logic                            a_perr,
   output logic                            b_perr
`endif
);

   localparam int AW = $clog2(MEMORY_DEPTH);

   if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
      $error("bram_dp_clr: RD_LATENCY must be within 1..%0d", MAX_RD_LATENCY);
   end

`ifdef BRAM_PARITY_EN
   localparam int MEM_W = DATA_WIDTH + 1;
   logic [MEM_W-1:0] a_word;
   assign a_word = {parity(64'(a_data)), a_data};
`else
   localparam int MEM_W = DATA_WIDTH;
   logic [MEM_W-1:0] a_word;
   assign a_word = a_data;
`endif

   logic [MEM_W-1:0] mem [MEMORY_DEPTH];

   bram_state_t   state;
   logic [AW-1:0] cnt;
   logic          idle;
   logic          b_hit;

   assign idle  = (state == IDLE);
   assign busy  = (state == CLEAR);
   assign b_hit = (B_BYPASS != 0) && a_wr && (a_address == b_address);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         case (state)
            CLEAR: begin
               cnt <= cnt + AW'(1);
               if (cnt == AW'(MEMORY_DEPTH - 1)) state <= IDLE;
            end
            IDLE: begin
               if (clear) begin
                  state <= CLEAR;
                  cnt   <= '0;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

   // The sweep owns the write port while busy; port-A writes are dropped.
   always_ff @(posedge clk) begin
      if (!idle)     mem[cnt]       <= '0;
      else if (a_wr) mem[a_address] <= a_word;
   end

   // ---- stage p0: registered array read (read-first on port A) ----
   logic [MEM_W-1:0] word_a_p0, word_b_p0;
   logic             vld_a_p0,  vld_b_p0;

   always_ff @(posedge clk) begin
      word_a_p0 <= mem[a_address];
      word_b_p0 <= b_hit ? a_word : mem[b_address];
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         vld_a_p0 <= 1'b0;
         vld_b_p0 <= 1'b0;
      end else begin
         vld_a_p0 <= idle & a_rd;
         vld_b_p0 <= idle & b_rd;
      end
   end

   // ---- stages p1..: return pipeline per port ----
`ifdef BRAM_PARITY_EN
   logic perr_a_p0, perr_b_p0;
   assign perr_a_p0 = parity(64'(word_a_p0[DATA_WIDTH-1:0])) != word_a_p0[DATA_WIDTH];
   assign perr_b_p0 = parity(64'(word_b_p0[DATA_WIDTH-1:0])) != word_b_p0[DATA_WIDTH];
`endif

   bram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_pipe_a (
      .clk     (clk),
      .rstN    (rstN),
      .vld_in  (vld_a_p0),
      .data_in (word_a_p0[DATA_WIDTH-1:0]),
`ifdef BRAM_PARITY_EN
      .perr_in (perr_a_p0),
      .perr    (a_perr),
`endif
      .q       (a_q),
      .valid   (a_valid)
   );

   bram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_pipe_b (
      .clk     (clk),
      .rstN    (rstN),
      .vld_in  (vld_b_p0),
      .data_in (word_b_p0[DATA_WIDTH-1:0]),
`ifdef BRAM_PARITY_EN
      .perr_in (perr_b_p0),
      .perr    (b_perr),
`endif
      .q       (b_q),
      .valid   (b_valid)
   );

endmodule

// File: tb/tb_bram_dp_clr.sv
// Directed self-checking bench for bram_dp_clr (RD_LATENCY = 2); parity
// checks compile in only when BRAM_PARITY_EN is defined.
module tb_bram_dp_clr;
   import bram_pkg::*;

   localparam int DEPTH = 4096;
   localparam int DW    = 16;
   localparam int LAT   = 2;
   localparam int BYP   = 0;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rstN;
   logic          clear;
   logic          busy;
   logic          a_wr, a_rd, b_rd;
   logic [AW-1:0] a_address, b_address;
   logic [DW-1:0] a_data, a_q, b_q;
   logic          a_valid, b_valid;
`ifdef BRAM_PARITY_EN
   logic          a_perr, b_perr;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bram_dp_clr #(
      .MEMORY_DEPTH(DEPTH), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .B_BYPASS(BYP)
   ) dut (
      .clk(clk), .rstN(rstN), .clear(clear), .busy(busy),
      .a_wr(a_wr), .a_rd(a_rd), .a_address(a_address), .a_data(a_data),
      .a_q(a_q), .a_valid(a_valid),
      .b_rd(b_rd), .b_address(b_address), .b_q(b_q), .b_valid(b_valid)
`ifdef BRAM_PARITY_EN
      , .a_perr(a_perr), .b_perr(b_perr)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_a(input int addr, input logic [DW-1:0] data);
      a_wr = 1'b1; a_address = AW'(addr); a_data = data;
      tick();
      a_wr = 1'b0;
   endtask

   // One-cycle request, then wait until the result is on the outputs.
   task automatic read_ab(input bit do_a, input int aa, input bit do_b, input int ba);
      a_rd = do_a; a_address = AW'(aa);
      b_rd = do_b; b_address = AW'(ba);
      tick();
      a_rd = 1'b0; b_rd = 1'b0;
      repeat (LAT) tick();
   endtask

   task automatic wait_sweep(output int n);
      n = 0;
      while (busy === 1'b1 && n < 6000) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, va, vb;
      logic [DW-1:0] lastq;

      rstN = 1'b0; clear = 1'b0; a_wr = 1'b0; a_rd = 1'b0; b_rd = 1'b0;
      a_address = '0; b_address = '0; a_data = '0;
      repeat (3) tick();
      check("rst_a_q",     32'(a_q),     32'h0);
      check("rst_b_q",     32'(b_q),     32'h0);
      check("rst_a_valid", 32'(a_valid), 32'h0);
      check("rst_b_valid", 32'(b_valid), 32'h0);
      check("rst_busy",    32'(busy),    32'h1);

      rstN = 1'b1;
      wait_sweep(n);
      check("sweep_len", 32'(n), 32'd4096);

      read_ab(1, 0, 1, 4095);
      check("rd0_valid",    32'(a_valid), 32'h1);
      check("rd0_q",        32'(a_q),     32'h0);
      check("rdb4095_valid", 32'(b_valid), 32'h1);
      check("rdb4095_q",     32'(b_q),     32'h0);
      read_ab(1, 2047, 0, 0);
      check("rd2047_q", 32'(a_q), 32'h0);
      read_ab(1, 4095, 0, 0);
      check("rd4095_valid", 32'(a_valid), 32'h1);
      check("rd4095_q",     32'(a_q),     32'h0);

      // back-to-back reads: valid at ticks LAT+1..LAT+3 after the first request
      write_a(1, 16'd5);
      write_a(2, 16'd10);
      write_a(3, 16'd12);
      for (int j = 0; j < LAT + 5; j++) begin
         int idx;
         if (j < 3) begin a_rd = 1'b1; a_address = AW'(j + 1); end
         else       a_rd = 1'b0;
         tick();
         idx = j - LAT;
         if (idx >= 0 && idx < 3) begin
            check($sformatf("b2b_valid_%0d", j), 32'(a_valid), 32'h1);
            check($sformatf("b2b_q_%0d", j), 32'(a_q), (idx == 0) ? 32'd5 : (idx == 1) ? 32'd10 : 32'd12);
         end else begin
            check($sformatf("b2b_novalid_%0d", j), 32'(a_valid), 32'h0);
         end
      end
      check("b2b_q_hold", 32'(a_q), 32'd12);
      read_ab(0, 0, 1, 2);
      check("b_rd2_q", 32'(b_q), 32'd10);

      // collision: write 7 while both ports read 7
      write_a(7, 16'h00AA);
      a_wr = 1'b1; a_rd = 1'b1; a_address = 7; a_data = 16'h1234;
      b_rd = 1'b1; b_address = 7;
      tick();
      a_wr = 1'b0; a_rd = 1'b0; b_rd = 1'b0;
      repeat (LAT) tick();
      check("coll_a_valid", 32'(a_valid), 32'h1);
      check("coll_a_q",     32'(a_q),     32'h00AA);
      check("coll_b_valid", 32'(b_valid), 32'h1);
      check("coll_b_q",     32'(b_q),     (BYP != 0) ? 32'h1234 : 32'h00AA);
      tick();
      check("coll_valid_pulse", 32'(a_valid), 32'h0);
      check("coll_q_hold",      32'(a_q),     32'h00AA);
      read_ab(1, 7, 0, 0);
      check("coll_after_q", 32'(a_q), 32'h1234);

      // clear with an in-flight read, then ignored requests during the sweep
      write_a(9, 16'hBEEF);
      read_ab(1, 9, 0, 0);
      check("pre_clear_q", 32'(a_q), 32'hBEEF);
      clear = 1'b1; a_rd = 1'b1; a_address = 7;
      tick();
      clear = 1'b0;
      check("clear_busy", 32'(busy), 32'h1);
      a_wr = 1'b1; a_rd = 1'b1; a_address = 20; a_data = 16'h5555;
      b_rd = 1'b1; b_address = 20;
      n = 0; va = 0; vb = 0; lastq = '0;
      while (busy === 1'b1 && n < 6000) begin
         tick();
         n++;
         if (a_valid === 1'b1) begin va++; lastq = a_q; end
         if (b_valid === 1'b1) vb++;
      end
      a_wr = 1'b0; a_rd = 1'b0; b_rd = 1'b0;
      check("clear_len",      32'(n),     32'd4096);
      check("clear_a_valids", 32'(va),    32'd1);
      check("inflight_q",     32'(lastq), 32'h1234);
      check("clear_b_valids", 32'(vb),    32'd0);
      va = 0;
      repeat (LAT + 2) begin
         tick();
         if (a_valid === 1'b1 || b_valid === 1'b1) va++;
      end
      check("no_queued_valid", 32'(va), 32'd0);
      read_ab(1, 9, 1, 20);
      check("cleared_9",   32'(a_q), 32'h0);
      check("ignored_wr",  32'(b_q), 32'h0);

      // reset in the middle of a sweep restarts it
      write_a(3000, 16'h0077);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (1000) tick();
      rstN = 1'b0;
      tick();
      check("midrst_busy",  32'(busy),    32'h1);
      check("midrst_valid", 32'(a_valid), 32'h0);
      repeat (2) tick();
      rstN = 1'b1;
      wait_sweep(n);
      check("restart_len", 32'(n), 32'd4096);
      read_ab(1, 3000, 0, 0);
      check("restart_3000", 32'(a_q), 32'h0);

`ifdef BRAM_PARITY_EN
      write_a(4, 16'h0001);
      write_a(5, 16'h0003);
      check("par5_stored", 32'(dut.mem[5][DW]), 32'(parity(64'(16'h0003))));
      dut.mem[4][DW] = ~dut.mem[4][DW];
      read_ab(1, 4, 1, 4);
      check("perr_a_valid", 32'(a_valid), 32'h1);
      check("perr_a",       32'(a_perr),  32'h1);
      check("perr_b",       32'(b_perr),  32'h1);
      check("perr_a_q",     32'(a_q),     32'h0001);
      read_ab(1, 5, 0, 0);
      check("perr_clean", 32'(a_perr), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_dp_clr.md
Name: bram_dp_clr

Overview:
- Parametrised successor to the single-port bram.
- Port A is read/write; port B is read-only.
- Read latency is configurable, with per-port valid flags.
- A hardware clear engine zeroes the whole array after reset and on command.
- Sits between the serial-bus slave datapath (port A) and a monitor/readback path (port B).

Parameters:
- MEMORY_DEPTH, 4096, number of words; must be a power of 2, ≥ 4.
- DATA_WIDTH, 16, word width in bits.
- RD_LATENCY, 1, cycles from read request to data valid; legal values 1..3.
- B_BYPASS, 0, port-B read of the address port A writes in the same cycle: 0 returns old data, 1 returns new data.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstN  in  1  asynchronous active-low reset
- clear  in  1  pulse to start a full-array zero sweep; honoured only in IDLE
- busy  out  1  high while the clear sweep runs
- a_wr  in  1  port-A write strobe
- a_rd  in  1  port-A read strobe
- a_address  in  $clog2(MEMORY_DEPTH)  port-A address
- a_data  in  DATA_WIDTH  port-A write data
- a_q  out  DATA_WIDTH  port-A read data
- a_valid  out  1  a_q valid, one-cycle pulse per accepted read
- b_rd  in  1  port-B read strobe
- b_address  in  $clog2(MEMORY_DEPTH)  port-B address
- b_q  out  DATA_WIDTH  port-B read data
- b_valid  out  1  b_q valid, one-cycle pulse per accepted read

Behaviour:
- Reset (rstN low, asynchronous):
  - a_q, b_q = 0; a_valid, b_valid = 0; busy = 1; clear counter = 0; state = CLEAR.
  - Array contents are not reset; the sweep provides zeroing.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. When cnt = MEMORY_DEPTH-1 is written, go to IDLE. Sweep takes exactly MEMORY_DEPTH cycles after rstN deasserts. busy = 1 throughout; busy falls on the edge entering IDLE.
  - IDLE: clear = 1 → CLEAR with cnt = 0 and busy = 1 on the next edge. Port requests in that same cycle are still serviced.
  - Reset during CLEAR restarts the sweep at address 0.
- Request acceptance:
  - In CLEAR, a_wr, a_rd and b_rd are ignored. No write occurs, no valid is generated, and requests are not queued.
  - In IDLE, every strobe is accepted. There is no backpressure.
- Port A write: mem[a_address] <= a_data on the edge where a_wr = 1.
- Port A read is read-first. With a_wr and a_rd both high, a_q returns the pre-write contents.
- Read latency: a read accepted at edge t gives data and valid = 1 at edge t+RD_LATENCY.
  - Valid is high for exactly one cycle per request.
  - Back-to-back reads give back-to-back valids.
  - q holds its last value when valid is low.
- Port B collision (b_rd with a_wr, same address, same cycle):
  - B_BYPASS = 0: b_q returns old data.
  - B_BYPASS = 1: b_q returns a_data.
- Reads in flight when clear is accepted still complete with pre-clear data.
- Address is unsigned full-range. No out-of-range case exists because depth is a power of 2.

Optional Feature:
- Macro: BRAM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit computed from the write data; the clear sweep writes parity 0.
  - New outputs a_perr and b_perr (1 bit each) pulse together with the matching valid when the stored parity mismatches the recomputed parity. Both reset to 0.
- When undefined: the array is DATA_WIDTH wide and the perr ports do not exist.

Decomposition:
- Package bram_pkg holds:
  - typedef enum logic {CLEAR, IDLE} bram_state_t
  - constant MAX_RD_LATENCY = 3
  - function parity(), used by the RTL and the bench
- Sub-module bram_rd_pipe(DATA_WIDTH, RD_LATENCY) is instantiated once per port.
  - It contains the shift register for data, valid and perr after the one-cycle array read.

Test Plan:
- Release reset, count busy cycles → busy = 1 for exactly 4096 cycles. Then reads of addresses 0, 2047 and 4095 return 0 with valid.
- IDLE, RD_LATENCY = 2: write 1←5, 2←10, 3←12, then read 1, 2, 3 on consecutive cycles → a_valid high for 3 consecutive cycles starting 2 cycles after the first read, with a_q = 5, 10, 12.
- mem[7] = 0x00AA; same cycle a_wr 7←0x1234, a_rd 7, b_rd 7 → a_q = 0x00AA. b_q = 0x00AA with B_BYPASS = 0, 0x1234 with B_BYPASS = 1. A following read of 7 returns 0x1234.
- Write 9←0xBEEF, pulse clear, issue a_wr and a_rd during busy → no a_valid during the sweep. After busy falls, address 9 reads 0 and the ignored write has not landed.
- Assert rstN low at clear count ≈ 1000 → busy stays 1 and the sweep restarts. busy falls exactly 4096 cycles after release.
- BRAM_PARITY_EN defined: write 4←0x0001, force the stored parity bit flipped by hierarchical deposit, read 4 → a_perr = 1 in the same cycle as a_valid. Reading an unflipped word gives a_perr = 0.
